commit_tracer: RTL and testbench
================================

COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter DEPTH, default 8, trace FIFO entries (power of two, >=4).
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; leaves IDLE.
REQ-005 global_en  out  1  CPU run enable.
REQ-006 commit, commit_halt, commit_reg_we, commit_dmem_we  in  1 each  CPU commit port flags.
REQ-007 commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd  in  32 each  CPU commit port data.
REQ-008 commit_reg_wa  in  5  committed register write address.
REQ-009 debug_reg_ra  out  5 / debug_reg_rd  in  32  register-file debug read; rd is combinational from ra.
REQ-010 trace_valid  out  1 / trace_ready  in  1  trace output handshake.
REQ-011 trace_type  out  2 / trace_addr  out  32 / trace_data  out  32  FIFO head record.
REQ-012 inst_count  out  32  accepted commits; done  out  1  dump finished.

Function
REQ-013 States IDLE, RUN, DUMP, DONE: IDLE->RUN on start; RUN->DUMP on accepted halt; DUMP->DONE after register 31 pushed; DONE holds until reset.
REQ-014 en_q is global_en registered; a commit is accepted in a cycle only when commit=1 and en_q=1, so a commit held while the CPU is stalled is never counted twice.
REQ-015 global_en = (state==RUN) and (count < DEPTH-1) and not (accepted commit with commit_halt=1) in the same cycle.
REQ-016 Accepted commit in RUN increments inst_count by 1, 32-bit wrap.
REQ-017 Record pushed per accepted commit:
- commit_reg_we=1 and commit_reg_wa!=0: type 0, addr={27'b0,wa}, data=commit_reg_wd.
- else commit_dmem_we=1: type 1, addr=commit_dmem_wa, data=commit_dmem_wd.
- else no record.
- Register write takes priority when both set.
REQ-018 Accepted halt pushes type 3, addr=commit_pc, data=inst_count value after the increment; the write record is not pushed for the halt commit.
REQ-019 Commits arriving in IDLE, DUMP or DONE are ignored.
REQ-020 DUMP: index idx runs 1..31, starting at 1.
- debug_reg_ra=idx.
- When count<DEPTH, push type 2, addr={27'b0,idx}, data=debug_reg_rd, then increment idx.
- Outside DUMP, debug_reg_ra=0.
REQ-021 trace_valid = (count!=0); head record presented; pop on trace_valid and trace_ready; head stable while valid and not ready.
REQ-022 Simultaneous push and pop at any count: both occur, count unchanged; pop at empty is ignored.
REQ-023 RUN gating (REQ-015) guarantees no overflow; a push never occurs at count==DEPTH.
REQ-024 done=1 only in DONE, and only once all 31 dump records are pushed (FIFO may still hold them).

Reset
REQ-025 On rst (asynchronous, active-high), immediately:
- state=IDLE, en_q=0, idx=1, FIFO empty (read/write pointers and count zero).
- inst_count=0; global_en=0; trace_valid=0; done=0; debug_reg_ra=0.
REQ-026 Reset mid-RUN or mid-DUMP discards all buffered records.

Structure
REQ-027 A shared package holds the trace_type encodings (REG=0, MEM=1, DUMP=2, HALT=3), the state encoding and the 69-bit record width.
REQ-028 The FIFO is one sub-module, trace_fifo (parameter DEPTH, push/pop/full/empty/count); the FSM, gating and counter live in commit_tracer.

Verification
REQ-029 Start, 3 accepted commits writing x5=0x11, x0=0x22, then mem[0x100]=0x33 -> records (0,5,0x11), (1,0x100,0x33); x0 skipped; inst_count=3.
REQ-030 commit held high for 4 cycles while global_en=0 -> inst_count increments once.
REQ-031 trace_ready=0 with a commit every cycle -> global_en drops once count reaches DEPTH-1; count peaks at DEPTH, no record lost; ready=1 drains in order.
REQ-032 Halt at pc 0x40 after 9 commits -> global_en=0 in the halt cycle; record (3,0x40,10); then 31 records (2,i,reg[i]), i=1..31; done=1.
REQ-033 During DUMP, hold trace_ready=0 -> idx stalls at the DEPTH-th push; resumes on ready with no gap or duplicate.
REQ-034 Assert rst during DUMP at idx=12 -> all outputs at reset values immediately; state IDLE; FIFO empty.

Source files
------------

// File: rtl/commit_tracer_pkg.sv
// Shared definitions for the commit tracer: trace record layout, trace type
// and FSM state encodings, and a record builder used by the tracer core.
package commit_tracer_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned REC_W    = 69;
  localparam int unsigned LAST_REG = 31;

  // Encoding presented on trace_type.
  typedef enum logic [1:0] {
    TT_REG  = 2'd0,
    TT_MEM  = 2'd1,
    TT_DUMP = 2'd2,
    TT_HALT = 2'd3
  } trace_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One FIFO entry; rsvd pads the record to REC_W and is always written zero.
  typedef struct packed {
    logic [2:0]      rsvd;
    trace_type_e     ttype;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } trace_rec_t;

  function automatic trace_rec_t make_rec(input trace_type_e     ttype,
                                          input logic [XLEN-1:0] addr,
                                          input logic [XLEN-1:0] data);
    trace_rec_t r;
    r.rsvd  = '0;
    r.ttype = ttype;
    r.addr  = addr;
    r.data  = data;
    return r;
  endfunction

endpackage

// File: rtl/commit_tracer_fifo.sv
// trace_fifo: synchronous FIFO holding trace records.
// Ports: clk/rst (async active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o is the current head),
// full_o/empty_o/count_o occupancy status.
module trace_fifo
  import commit_tracer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = REC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pop at empty is dropped; a push at full is only taken alongside a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/commit_tracer.sv
// commit_tracer: watches a CPU commit port, records register/memory writes
// into a trace FIFO, and after the CPU halts dumps registers x1..x31 through
// the register-file debug read port.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               one-cycle pulse leaving IDLE
//   global_en           CPU run enable (combinational, see gating below)
//   commit*             CPU commit port
//   debug_reg_ra/rd     register-file debug read (rd combinational from ra)
//   trace_*             FIFO head record with valid/ready handshake
//   inst_count, done    accepted commit count, dump-finished flag
module commit_tracer
  import commit_tracer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              global_en,
  input  logic              commit,
  input  logic              commit_halt,
  input  logic              commit_reg_we,
  input  logic              commit_dmem_we,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [XLEN-1:0]   commit_inst,
  input  logic [XLEN-1:0]   commit_reg_wd,
  input  logic [XLEN-1:0]   commit_dmem_wa,
  input  logic [XLEN-1:0]   commit_dmem_wd,
  input  logic [RA_W-1:0]   commit_reg_wa,
  output logic [RA_W-1:0]   debug_reg_ra,
  input  logic [XLEN-1:0]   debug_reg_rd,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [1:0]        trace_type,
  output logic [XLEN-1:0]   trace_addr,
  output logic [XLEN-1:0]   trace_data,
  output logic [XLEN-1:0]   inst_count,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              en_q;
  logic [RA_W-1:0]   idx_q, idx_d;
  logic [RA_W-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   inst_count_q, inst_count_d;
  logic              done_q, done_d;

  logic              accept;
  logic              halt_acc;
  logic              push;
  trace_rec_t        push_rec;
  logic              pop;
  logic [REC_W-1:0]  fifo_rdata;
  trace_rec_t        head_rec;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_sink;

  // en_q marks a cycle the CPU was enabled for, so a commit held during a
  // stall is taken only once.
  assign accept   = commit && en_q && (state_q == ST_RUN);
  assign halt_acc = accept && commit_halt;

  // Stop the CPU one entry early: the commit already in flight still fits.
  assign global_en = (state_q == ST_RUN) &&
                     (fifo_count < CNT_W'(DEPTH - 1)) &&
                     !halt_acc;

  assign trace_valid  = !fifo_empty;
  assign pop          = trace_valid && trace_ready;
  assign head_rec     = fifo_rdata;
  assign trace_type   = head_rec.ttype;
  assign trace_addr   = head_rec.addr;
  assign trace_data   = head_rec.data;
  assign inst_count   = inst_count_q;
  assign done         = done_q;
  assign debug_reg_ra = ra_q;
  assign unused_sink  = ^{commit_inst, head_rec.rsvd};

  // Next-state, record selection and counters.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    inst_count_d = inst_count_q;
    done_d       = done_q;
    push         = 1'b0;
    push_rec     = make_rec(TT_REG, '0, '0);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          inst_count_d = inst_count_q + XLEN'(1);
          // Halt replaces any write record carried by the same commit.
          if (commit_halt) begin
            push     = 1'b1;
            push_rec = make_rec(TT_HALT, commit_pc, inst_count_q + XLEN'(1));
            state_d  = ST_DUMP;
            idx_d    = RA_W'(1);
          end else if (commit_reg_we && (commit_reg_wa != '0)) begin
            push     = 1'b1;
            push_rec = make_rec(TT_REG, XLEN'(commit_reg_wa), commit_reg_wd);
          end else if (commit_dmem_we) begin
            push     = 1'b1;
            push_rec = make_rec(TT_MEM, commit_dmem_wa, commit_dmem_wd);
          end
        end
      end
      ST_DUMP: begin
        // One register per cycle while there is room; idx stalls otherwise.
        if (!fifo_full) begin
          push     = 1'b1;
          push_rec = make_rec(TT_DUMP, XLEN'(idx_q), debug_reg_rd);
          if (idx_q == RA_W'(LAST_REG)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + RA_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Debug read address follows idx only while dumping.
    ra_d = (state_d == ST_DUMP) ? idx_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      idx_q        <= RA_W'(1);
      ra_q         <= '0;
      inst_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= global_en;
      idx_q        <= idx_d;
      ra_q         <= ra_d;
      inst_count_q <= inst_count_d;
      done_q       <= done_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_commit_tracer.sv
// Directed bench for commit_tracer (DEPTH=8) with hand-computed expectations.
module tb_commit_tracer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        global_en;
  logic        commit, commit_halt, commit_reg_we, commit_dmem_we;
  logic [31:0] commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd;
  logic [4:0]  commit_reg_wa;
  logic [4:0]  debug_reg_ra;
  logic [31:0] debug_reg_rd;
  logic        trace_valid, trace_ready;
  logic [1:0]  trace_type;
  logic [31:0] trace_addr, trace_data;
  logic [31:0] inst_count;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Register file model: reg[i] = 0xC0DE_00ii.
  assign debug_reg_rd = {16'hC0DE, 11'd0, debug_reg_ra};

  commit_tracer #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .global_en      (global_en),
    .commit         (commit),
    .commit_halt    (commit_halt),
    .commit_reg_we  (commit_reg_we),
    .commit_dmem_we (commit_dmem_we),
    .commit_pc      (commit_pc),
    .commit_inst    (commit_inst),
    .commit_reg_wd  (commit_reg_wd),
    .commit_dmem_wa (commit_dmem_wa),
    .commit_dmem_wd (commit_dmem_wd),
    .commit_reg_wa  (commit_reg_wa),
    .debug_reg_ra   (debug_reg_ra),
    .debug_reg_rd   (debug_reg_rd),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_type     (trace_type),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .inst_count     (inst_count),
    .done           (done)
  );

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] rec(input logic [1:0] t, input logic [31:0] a,
                                      input logic [31:0] d);
    return {t, a, d};
  endfunction

  function automatic logic [65:0] head();
    return {trace_type, trace_addr, trace_data};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_commit();
    commit = 1'b0; commit_halt = 1'b0; commit_reg_we = 1'b0; commit_dmem_we = 1'b0;
  endtask

  task automatic set_reg(input logic [4:0] wa, input logic [31:0] wd);
    commit = 1'b1; commit_halt = 1'b0; commit_reg_we = 1'b1; commit_dmem_we = 1'b0;
    commit_reg_wa = wa; commit_reg_wd = wd;
  endtask

  task automatic set_mem(input logic [31:0] wa, input logic [31:0] wd);
    commit = 1'b1; commit_halt = 1'b0; commit_reg_we = 1'b0; commit_dmem_we = 1'b1;
    commit_dmem_wa = wa; commit_dmem_wd = wd;
  endtask

  // Halt commit that also carries a register write, which must not be traced.
  task automatic set_halt(input logic [31:0] pc);
    commit = 1'b1; commit_halt = 1'b1; commit_reg_we = 1'b1; commit_dmem_we = 1'b0;
    commit_reg_wa = 5'd3; commit_reg_wd = 32'hDEAD; commit_pc = pc;
  endtask

  // Called at a negedge; returns two negedges later, first cycle with en_q=1.
  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0; cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; trace_ready = 1'b0;
    idle_commit();
    commit_pc = '0; commit_inst = 32'h13; commit_reg_wd = '0; commit_reg_wa = '0;
    commit_dmem_wa = '0; commit_dmem_wd = '0;
    cyc(2);

    // Reset state
    check("rst_global_en", 66'(global_en), 66'(0));
    check("rst_trace_valid", 66'(trace_valid), 66'(0));
    check("rst_done", 66'(done), 66'(0));
    check("rst_ra", 66'(debug_reg_ra), 66'(0));
    check("rst_inst_count", 66'(inst_count), 66'(0));
    rst = 1'b0; cyc();

    // Basic records: x5 write, x0 write skipped, memory write
    pulse_start();
    set_reg(5'd5, 32'h11); cyc();
    set_reg(5'd0, 32'h22); cyc();
    set_mem(32'h100, 32'h33); cyc();
    idle_commit();
    check("basic_inst_count", 66'(inst_count), 66'(3));
    check("basic_valid", 66'(trace_valid), 66'(1));
    check("basic_rec0", head(), rec(2'd0, 32'd5, 32'h11));
    trace_ready = 1'b1; cyc();
    check("basic_rec1", head(), rec(2'd1, 32'h100, 32'h33));
    cyc(); trace_ready = 1'b0;
    check("basic_empty", 66'(trace_valid), 66'(0));

    // Backpressure: fill to DEPTH, then a commit held through the stall
    for (int k = 1; k <= 7; k++) begin
      set_reg(5'(k), 32'(32'h100 + k)); cyc();
    end
    check("bp_ge_drop", 66'(global_en), 66'(0));
    set_reg(5'd8, 32'h108); cyc(4);
    idle_commit();
    check("bp_held_once", 66'(inst_count), 66'(11));
    check("bp_ge_low", 66'(global_en), 66'(0));
    trace_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("bp_drain%0d", k), head(), rec(2'd0, 32'(k), 32'(32'h100 + k)));
      cyc();
    end
    check("bp_drained", 66'(trace_valid), 66'(0));
    trace_ready = 1'b0;

    // Commits in IDLE are ignored
    rst = 1'b1; cyc(); rst = 1'b0;
    set_reg(5'd7, 32'h77); cyc(3);
    idle_commit();
    check("idle_inst_count", 66'(inst_count), 66'(0));
    check("idle_valid", 66'(trace_valid), 66'(0));

    // Halt after 9 commits, then dump with a stall
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      set_reg(5'd0, 32'(k)); cyc();
    end
    set_halt(32'h40);
    #1;
    check("halt_ge", 66'(global_en), 66'(0));
    cyc(); idle_commit();
    check("halt_inst_count", 66'(inst_count), 66'(10));
    check("halt_rec", head(), rec(2'd3, 32'h40, 32'd10));
    check("dump_ra_start", 66'(debug_reg_ra), 66'(1));
    cyc(9);
    check("dump_stall_ra", 66'(debug_reg_ra), 66'(8));
    check("dump_stall_done", 66'(done), 66'(0));
    trace_ready = 1'b1;
    check("dump_head_halt", head(), rec(2'd3, 32'h40, 32'd10));
    cyc();
    for (int i = 1; i <= 31; i++) begin
      check($sformatf("dump_rec%0d", i), head(),
            rec(2'd2, 32'(i), {16'hC0DE, 11'd0, 5'(i)}));
      cyc();
    end
    check("dump_empty", 66'(trace_valid), 66'(0));
    check("dump_done", 66'(done), 66'(1));
    check("dump_ra_done", 66'(debug_reg_ra), 66'(0));

    // Commits in DONE are ignored
    set_reg(5'd9, 32'h99); cyc(2);
    idle_commit();
    check("done_inst_count", 66'(inst_count), 66'(10));
    check("done_valid", 66'(trace_valid), 66'(0));
    check("done_hold", 66'(done), 66'(1));

    // Reset in the middle of the dump
    rst = 1'b1; cyc(); rst = 1'b0;
    trace_ready = 1'b1;
    pulse_start();
    set_halt(32'h80); cyc();
    idle_commit();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (debug_reg_ra == 5'd12) found = 1'b1;
      else cyc();
    end
    check("mid_reach_idx12", 66'(debug_reg_ra), 66'(12));
    check("mid_valid_before", 66'(trace_valid), 66'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ge", 66'(global_en), 66'(0));
    check("mid_rst_valid", 66'(trace_valid), 66'(0));
    check("mid_rst_done", 66'(done), 66'(0));
    check("mid_rst_ra", 66'(debug_reg_ra), 66'(0));
    check("mid_rst_inst_count", 66'(inst_count), 66'(0));
    cyc(); rst = 1'b0; cyc(2);
    check("mid_idle_ge", 66'(global_en), 66'(0));
    check("mid_idle_valid", 66'(trace_valid), 66'(0));
    check("mid_idle_ra", 66'(debug_reg_ra), 66'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
